// File: rtl/rv32_run_control_if.sv
// Run-control bundle between the sequencer (slave) and the bench/core harness (master).
// The step line only exists when RUN_CONTROL_STEP_EN is defined.
interface rv32_run_control_if #(
    parameter int PC_WIDTH    = 32,
    parameter int CYCLE_WIDTH = 16
);
    logic                   start;
    logic [PC_WIDTH-1:0]    pc;
`ifdef RUN_CONTROL_STEP_EN
    logic                   step;
`endif
    logic                   core_reset_n;
    logic                   enable;
    logic [CYCLE_WIDTH-1:0] cycle_count;
    logic                   halted;
    logic                   timeout;
    logic                   done;

    modport master (
        output start,
        output pc,
`ifdef RUN_CONTROL_STEP_EN
        output step,
`endif
        input  core_reset_n,
        input  enable,
        input  cycle_count,
        input  halted,
        input  timeout,
        input  done
    );

    modport slave (
        input  start,
        input  pc,
`ifdef RUN_CONTROL_STEP_EN
        input  step,
`endif
        output core_reset_n,
        output enable,
        output cycle_count,
        output halted,
        output timeout,
        output done
    );
endinterface

// File: rtl/rv32_run_control.sv
// Run-control sequencer: reset hold, enable, and end-of-run detection (halt PC, PC stall, budget).
// Optional macro RUN_CONTROL_STEP_EN turns enable into one pulse per rising edge of step.
module rv32_run_control #(
    parameter int                     PC_WIDTH     = 32,
    parameter int                     CYCLE_WIDTH  = 16,
    parameter int                     MAX_CYCLES   = 50,
    parameter int                     RESET_CYCLES = 4,
    parameter int                     STALL_LIMIT  = 3,
    parameter logic [PC_WIDTH-1:0]    HALT_PC      = PC_WIDTH'(32'hFFFF_FFFC)
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    rv32_run_control_if.slave    ctrl_if
);
    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_HOLD,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    state_t                 r_state;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [CYCLE_WIDTH-1:0] r_cycle_count;
    logic [PC_WIDTH-1:0]    r_pc_prev;
    logic                   r_prev_valid;
    logic [STALL_W-1:0]     r_stall_cnt;
    logic                   r_core_reset_n;
    logic                   r_enable;
    logic                   r_halted;
    logic                   r_timeout;
    logic                   r_done;

    state_t                 w_state_next;
    logic [HOLD_W-1:0]      w_hold_cnt_next;
    logic [CYCLE_WIDTH-1:0] w_cycle_count_next;
    logic [PC_WIDTH-1:0]    w_pc_prev_next;
    logic                   w_prev_valid_next;
    logic [STALL_W-1:0]     w_stall_cnt_next;
    logic                   w_core_reset_n_next;
    logic                   w_enable_next;
    logic                   w_halted_next;
    logic                   w_timeout_next;
    logic                   w_done_next;

    logic                   w_pc_repeat;
    logic                   w_stall_hit;
    logic                   w_halt_hit;
    logic                   w_budget_hit;
    logic                   w_hold_last;
    logic                   w_enable_run;
    logic                   w_enable_on_entry;

`ifdef RUN_CONTROL_STEP_EN
    // enable is only raised for the cycle after a step rising edge; that cycle's edge is the RUN edge
    logic r_step_d;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= ctrl_if.step;
        end
    end

    assign w_enable_run      = ctrl_if.step & ~r_step_d;
    assign w_enable_on_entry = 1'b0;
`else
    assign w_enable_run      = 1'b1;
    assign w_enable_on_entry = 1'b1;
`endif

    assign w_pc_repeat  = r_prev_valid && (ctrl_if.pc == r_pc_prev);
    assign w_stall_hit  = (STALL_LIMIT != 0) && w_pc_repeat &&
                          (({1'b0, r_stall_cnt} + 1'b1) == (STALL_W + 1)'(STALL_LIMIT));
    assign w_halt_hit   = (ctrl_if.pc == HALT_PC) || w_stall_hit;
    assign w_budget_hit = ((r_cycle_count + 1'b1) == CYCLE_WIDTH'(MAX_CYCLES));
    assign w_hold_last  = ((r_hold_cnt + 1'b1) == HOLD_W'(RESET_CYCLES));

    always_comb begin
        w_state_next        = r_state;
        w_hold_cnt_next     = r_hold_cnt;
        w_cycle_count_next  = r_cycle_count;
        w_pc_prev_next      = r_pc_prev;
        w_prev_valid_next   = r_prev_valid;
        w_stall_cnt_next    = r_stall_cnt;
        w_core_reset_n_next = r_core_reset_n;
        w_enable_next       = r_enable;
        w_halted_next       = r_halted;
        w_timeout_next      = r_timeout;
        w_done_next         = r_done;

        case (r_state)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (ctrl_if.start) begin
                    w_state_next        = S_RESET_HOLD;
                    w_hold_cnt_next     = '0;
                    w_cycle_count_next  = '0;
                    w_halted_next       = 1'b0;
                    w_timeout_next      = 1'b0;
                    w_done_next         = 1'b0;
                    w_core_reset_n_next = 1'b0;
                    w_enable_next       = 1'b0;
                end
            end

            S_RESET_HOLD: begin
                w_hold_cnt_next = r_hold_cnt + 1'b1;
                if (w_hold_last) begin
                    w_state_next        = S_RUN;
                    w_core_reset_n_next = 1'b1;
                    w_enable_next       = w_enable_on_entry;
                    w_prev_valid_next   = 1'b0;
                    w_stall_cnt_next    = '0;
                end
            end

            S_RUN: begin
                // r_enable high means the core advances on this edge, so it is a RUN edge
                if (r_enable) begin
                    w_cycle_count_next = r_cycle_count + 1'b1;
                    w_pc_prev_next     = ctrl_if.pc;
                    w_prev_valid_next  = 1'b1;
                    if ((STALL_LIMIT != 0) && w_pc_repeat) begin
                        w_stall_cnt_next = r_stall_cnt + 1'b1;
                    end else begin
                        w_stall_cnt_next = '0;
                    end

                    if (w_halt_hit) begin
                        w_state_next  = S_HALTED;
                        w_halted_next = 1'b1;
                        w_done_next   = 1'b1;
                        w_enable_next = 1'b0;
                    end else if (w_budget_hit) begin
                        w_state_next   = S_TIMEOUT;
                        w_timeout_next = 1'b1;
                        w_done_next    = 1'b1;
                        w_enable_next  = 1'b0;
                    end else begin
                        w_enable_next = w_enable_run;
                    end
                end else begin
                    w_enable_next = w_enable_run;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_hold_cnt     <= '0;
            r_cycle_count  <= '0;
            r_pc_prev      <= '0;
            r_prev_valid   <= 1'b0;
            r_stall_cnt    <= '0;
            r_core_reset_n <= 1'b0;
            r_enable       <= 1'b0;
            r_halted       <= 1'b0;
            r_timeout      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_hold_cnt     <= w_hold_cnt_next;
            r_cycle_count  <= w_cycle_count_next;
            r_pc_prev      <= w_pc_prev_next;
            r_prev_valid   <= w_prev_valid_next;
            r_stall_cnt    <= w_stall_cnt_next;
            r_core_reset_n <= w_core_reset_n_next;
            r_enable       <= w_enable_next;
            r_halted       <= w_halted_next;
            r_timeout      <= w_timeout_next;
            r_done         <= w_done_next;
        end
    end

    assign ctrl_if.core_reset_n = r_core_reset_n;
    assign ctrl_if.enable       = r_enable;
    assign ctrl_if.cycle_count  = r_cycle_count;
    assign ctrl_if.halted       = r_halted;
    assign ctrl_if.timeout      = r_timeout;
    assign ctrl_if.done         = r_done;
endmodule

// File: tb/tb_rv32_run_control.sv
// Scoreboard bench for rv32_run_control: two instances (stall detect on / off) share stimulus.
module tb_rv32_run_control;
    localparam int          MAX0   = 50;
    localparam int          MAX1   = 30;
    localparam int          RST_C  = 4;
    localparam int          STALL0 = 3;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        tb_rst_n;
    logic        tb_start;
    logic [31:0] tb_pc;

    always #5 clk = ~clk;

    rv32_run_control_if #(.PC_WIDTH(32), .CYCLE_WIDTH(16)) if0 ();
    rv32_run_control_if #(.PC_WIDTH(32), .CYCLE_WIDTH(16)) if1 ();

    assign if0.start = tb_start;
    assign if0.pc    = tb_pc;
    assign if1.start = tb_start;
    assign if1.pc    = tb_pc;

    rv32_run_control #(
        .PC_WIDTH(32), .CYCLE_WIDTH(16), .MAX_CYCLES(MAX0),
        .RESET_CYCLES(RST_C), .STALL_LIMIT(STALL0), .HALT_PC(HALT)
    ) dut0 (
        .i_clock(clk), .i_reset_n(tb_rst_n), .ctrl_if(if0)
    );

    rv32_run_control #(
        .PC_WIDTH(32), .CYCLE_WIDTH(16), .MAX_CYCLES(MAX1),
        .RESET_CYCLES(RST_C), .STALL_LIMIT(0), .HALT_PC(HALT)
    ) dut1 (
        .i_clock(clk), .i_reset_n(tb_rst_n), .ctrl_if(if1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        bit h;
        bit t;
        int n;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] pcs [1:64];

    // Walk the PC trace: first HALT_PC or STALL repeats of one value ends the run, else the budget does.
    function automatic exp_t model(input int stall_limit, input int max_c);
        exp_t r;
        int   rep;
        r   = '{h: 1'b0, t: 1'b0, n: 0};
        rep = 0;
        for (int k = 1; k <= max_c; k++) begin
            if (k > 1 && pcs[k] == pcs[k-1]) rep++;
            else rep = 0;
            if (pcs[k] == HALT || (stall_limit != 0 && rep == stall_limit)) begin
                r.h = 1'b1;
                r.n = k;
                return r;
            end
            if (k == max_c) begin
                r.t = 1'b1;
                r.n = k;
                return r;
            end
        end
        return r;
    endfunction

    // Monitors: a rising done is the DUT's response; pop and compare.
    logic d0_prev = 1'b0;
    logic d1_prev = 1'b0;
    exp_t m0, m1;

    always @(negedge clk) begin
        if (if0.done && !d0_prev) begin
            if (q0.size() == 0) begin
                check(1'b0, "dut0 unexpected done", 1, 0);
            end else begin
                m0 = q0.pop_front();
                $display("txn dut0: halted=%0b timeout=%0b cycles=%0d (exp %0b %0b %0d)",
                         if0.halted, if0.timeout, if0.cycle_count, m0.h, m0.t, m0.n);
                check(if0.halted == m0.h && if0.timeout == m0.t, "dut0 flags",
                      {if0.halted, if0.timeout}, {m0.h, m0.t});
                check(if0.cycle_count == 16'(m0.n), "dut0 cycle_count", if0.cycle_count, m0.n);
            end
        end
        d0_prev <= if0.done;
    end

    always @(negedge clk) begin
        if (if1.done && !d1_prev) begin
            if (q1.size() == 0) begin
                check(1'b0, "dut1 unexpected done", 1, 0);
            end else begin
                m1 = q1.pop_front();
                $display("txn dut1: halted=%0b timeout=%0b cycles=%0d (exp %0b %0b %0d)",
                         if1.halted, if1.timeout, if1.cycle_count, m1.h, m1.t, m1.n);
                check(if1.halted == m1.h && if1.timeout == m1.t, "dut1 flags",
                      {if1.halted, if1.timeout}, {m1.h, m1.t});
                check(if1.cycle_count == 16'(m1.n), "dut1 cycle_count", if1.cycle_count, m1.n);
            end
        end
        d1_prev <= if1.done;
    end

    task automatic run_one(input bit abort);
        exp_t e0, e1;
        int   lo, en0, en1, idx, guard;
        e0 = model(STALL0, MAX0);
        e1 = model(0, MAX1);
        if (!abort) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        @(negedge clk) tb_start = 1'b1;
        @(negedge clk) tb_start = 1'b0;
        check(!if0.done && !if0.halted && !if0.timeout, "flags cleared on start",
              {if0.done, if0.halted, if0.timeout}, 0);
        check(if0.cycle_count == 16'd0, "cycle_count cleared on start", if0.cycle_count, 0);

        lo    = 0;
        guard = 0;
        while (!if0.core_reset_n && guard < 100) begin
            lo++;
            guard++;
            @(negedge clk);
        end
        check(lo == RST_C, "core_reset_n low cycles", lo, RST_C);

        idx   = 1;
        en0   = 0;
        en1   = 0;
        guard = 0;
        while ((if0.enable || if1.enable) && guard < 200) begin
            if (abort && if0.cycle_count == 16'd20) begin
                #1 tb_rst_n = 1'b0;
                #1;
                check(!if0.core_reset_n && !if0.enable && !if0.done && !if0.halted && !if0.timeout
                      && if0.cycle_count == 16'd0, "dut0 async reset clears outputs",
                      {if0.core_reset_n, if0.enable, if0.done, if0.halted, if0.timeout}, 0);
                check(!if1.core_reset_n && !if1.enable && !if1.done && if1.cycle_count == 16'd0,
                      "dut1 async reset clears outputs",
                      {if1.core_reset_n, if1.enable, if1.done}, 0);
                #1 tb_rst_n = 1'b1;
                repeat (3) @(negedge clk);
                check(!if0.core_reset_n && !if0.enable && !if0.done, "idle after reset release",
                      {if0.core_reset_n, if0.enable, if0.done}, 0);
                return;
            end
            en0 += int'(if0.enable);
            en1 += int'(if1.enable);
            tb_pc = pcs[idx];
            if (idx < 64) idx++;
            guard++;
            @(negedge clk);
        end
        if (abort) begin
            check(1'b0, "abort point cycle_count 20 reached", if0.cycle_count, 20);
        end else begin
            check(en0 == e0.n, "dut0 enable-high cycles", en0, e0.n);
            check(en1 == e1.n, "dut1 enable-high cycles", en1, e1.n);
            check(if0.done && if1.done, "done after run", {if0.done, if1.done}, 3);
            check(if0.core_reset_n && !if0.enable, "core_reset_n held, enable low after end",
                  {if0.core_reset_n, if0.enable}, 2);
        end
    endtask

    task automatic fill_linear();
        for (int k = 1; k <= 64; k++) pcs[k] = 32'((k - 1) * 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        tb_rst_n = 1'b0;
        tb_start = 1'b0;
        tb_pc    = '0;
        repeat (2) @(negedge clk);
        check(!if0.core_reset_n && !if0.enable && !if0.done && !if0.halted && !if0.timeout
              && if0.cycle_count == 16'd0, "reset state",
              {if0.core_reset_n, if0.enable, if0.done, if0.halted, if0.timeout}, 0);
        tb_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check(!if0.core_reset_n && !if0.enable, "idle without start",
              {if0.core_reset_n, if0.enable}, 0);

        fill_linear();
        run_one(1'b0);                      // free run to timeout

        fill_linear();
        pcs[10] = HALT;
        run_one(1'b0);                      // halt address on 10th RUN edge

        fill_linear();
        for (int k = 3; k <= 64; k++) pcs[k] = 32'd8;
        run_one(1'b0);                      // stall 0,4,8,8,8,8

        fill_linear();
        pcs[50] = HALT;
        run_one(1'b0);                      // halt and budget on the same edge

        fill_linear();
        run_one(1'b1);                      // async reset mid-run
        run_one(1'b0);                      // fresh run after abort

        for (int it = 0; it < 15; it++) begin
            for (int k = 1; k <= 64; k++) begin
                r = int'($urandom_range(0, 99));
                if (r < 3) pcs[k] = HALT;
                else if (r < 45 && k > 1) pcs[k] = pcs[k-1];
                else pcs[k] = 32'($urandom_range(0, 15) * 4);
            end
            run_one(1'b0);
        end

        repeat (2) @(negedge clk);
        check(q0.size() == 0 && q1.size() == 0, "scoreboard drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rv32_run_control.md
Name: rv32_run_control

Overview:
- Synthesizable run-control sequencer for the rv32 core bench; replaces the fixed "enable high, finish after a hard-coded delay" stimulus.
- On start, holds the core in reset for a programmable number of cycles, then drives the core enable.
- While running, watches the core PC and ends the run on a halt address, a PC self-loop stall, or a cycle-budget timeout.
- Reports a cycle count and sticky status flags.

Parameters:
- PC_WIDTH, 32, width of monitored PC.
- CYCLE_WIDTH, 16, width of cycle counter; MAX_CYCLES must be < 2^CYCLE_WIDTH.
- MAX_CYCLES, 50, run-cycle budget before timeout; must be >= 1.
- RESET_CYCLES, 4, cycles core_reset_n is held low after start; must be >= 1.
- STALL_LIMIT, 3, consecutive repeated-PC edges that count as a halt; 0 disables stall detection.
- HALT_PC, 32'hFFFF_FFFC, PC value that signals program end.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled at a rising edge in IDLE, HALTED or TIMEOUT.
- pc  input  PC_WIDTH  current core PC, sampled every RUN edge.
- step  input  1  single-step request; only present with RUN_CONTROL_STEP_EN.
- core_reset_n  output  1  active-low reset to the core.
- enable  output  1  core clock-enable.
- cycle_count  output  CYCLE_WIDTH  RUN edges completed.
- halted  output  1  sticky; run ended by HALT_PC or stall.
- timeout  output  1  sticky; run ended by budget exhaustion.
- done  output  1  sticky; halted | timeout.

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0): state=IDLE; all outputs 0, including core_reset_n=0. Internal stall_cnt=0, prev_valid=0. Reset asserted mid-run aborts immediately with no completion flag.
- States: IDLE, RESET_HOLD, RUN, HALTED, TIMEOUT.
- IDLE:
  - start=1 -> RESET_HOLD.
  - Same edge: hold counter=0, cycle_count=0, flags cleared, core_reset_n=0, enable=0.
- RESET_HOLD:
  - Hold counter increments each edge.
  - On the RESET_CYCLES-th edge -> RUN, core_reset_n<=1, enable<=1, prev_valid<=0, stall_cnt<=0.
  - core_reset_n is therefore low for exactly RESET_CYCLES cycles after the start edge.
- RUN, on each edge:
  - cycle_count<=cycle_count+1, pc_prev<=pc, prev_valid<=1.
  - Stall counter: if prev_valid && pc==pc_prev, stall_cnt<=stall_cnt+1; else stall_cnt<=0.
  - Halt condition: pc==HALT_PC, or (STALL_LIMIT!=0 && prev_valid && pc==pc_prev && stall_cnt+1==STALL_LIMIT).
  - Timeout condition: cycle_count+1==MAX_CYCLES.
  - Halt condition -> HALTED: halted<=1, done<=1, enable<=0.
  - Else timeout condition -> TIMEOUT: timeout<=1, done<=1, enable<=0.
  - Halt wins when both occur on the same edge.
  - cycle_count includes the terminating edge: it reads MAX_CYCLES on timeout.
- HALTED/TIMEOUT:
  - Outputs held; core_reset_n stays 1 so core state is inspectable.
  - start=1 -> RESET_HOLD with the same clearing as from IDLE.
- start is ignored in RESET_HOLD and RUN.
- Counter widths: stall_cnt is clog2(STALL_LIMIT+1) bits and cannot wrap before a halt. cycle_count never exceeds MAX_CYCLES.

Optional Feature:
- Macro: RUN_CONTROL_STEP_EN.
- Defined:
  - `step` port exists. In RUN, enable is a one-cycle pulse per rising edge of step (edge-detected internally).
  - Only pulsed edges are RUN edges: they increment cycle_count and update stall/halt/timeout logic.
  - Edges without a pulse hold all state.
- Undefined:
  - No step port; enable stays continuously high throughout RUN, as described above.

Test Plan:
- Free run to timeout: start pulse; pc=0,4,8,... never repeating or hitting HALT_PC -> core_reset_n low exactly 4 cycles, enable high 50 cycles, then timeout=1, done=1, halted=0, cycle_count=50, enable=0.
- Halt address: pc reaches 32'hFFFF_FFFC on the 10th RUN edge -> halted=1, done=1, cycle_count=10; enable low from the next cycle.
- Stall: pc sequence 0,4,8,8,8,8 -> halted on the 6th RUN edge (stall_cnt reaches 3), cycle_count=6, timeout=0. Repeat with STALL_LIMIT=0 -> no stall halt; timeout at 50.
- Simultaneous: pc=HALT_PC exactly on the 50th RUN edge -> halted=1, timeout=0, cycle_count=50.
- Async reset mid-RUN at cycle_count=20: reset_n low -> core_reset_n, enable and all flags 0 without waiting for a clock edge. After release, stays IDLE until start; start again -> fresh run, cycle_count restarts from 0.
- Restart after done: start=1 in HALTED -> flags cleared, RESET_HOLD 4 cycles, new run. With RUN_CONTROL_STEP_EN: 3 step pulses -> cycle_count=3 and exactly 3 enable pulses.
